// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned PC_STEP      = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word while decode stalls.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        pop,
  input  logic        clear,
  input  fetch_word_t din,
  output logic        full,
  output fetch_word_t dout
);

  // Clear beats load; load beats pop so pop+load leaves the new word held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, issues +4 word fetches, offers returned words
// to decode over valid/ready, absorbs backpressure, handles redirect and halt.
// Optional build macro: FETCH_PERF_EN adds transfer/stall counters.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] Addr_o,
  output logic              imem_req_o,
  input  logic [DATA_W-1:0] instr_i,
  output logic              if_valid_o,
  input  logic              if_ready_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_instr_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              halt_i,
  output logic              halted_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_stall_o
`endif
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              req_q;
  logic              pend_q;
  fetch_word_t       pend_word_q;
  fetch_word_t       live_word;
  fetch_word_t       resp_word;
  fetch_word_t       head_word;
  fetch_word_t       skid_word;
  logic              skid_full;
  logic              skid_load;
  logic              skid_pop;
  logic              resp_v;
  logic              xfer;

  assign Addr_o = pc_q;

  // Pick the oldest undelivered word and derive issue/handshake controls.
  always_comb begin
    live_word  = '{pc: FETCH_ADDR_W'(req_pc_q), instr: FETCH_DATA_W'(instr_i)};
    resp_v     = req_q | pend_q;
    resp_word  = pend_q ? pend_word_q : live_word;
    head_word  = skid_full ? skid_word : resp_word;
    if_valid_o = ~redirect_i & (skid_full | resp_v);
    xfer       = if_valid_o & if_ready_i;
    imem_req_o = rst_n & (state_q == RUN) & ~skid_full & ~redirect_i;
    skid_pop   = skid_full & xfer;
    skid_load  = ~redirect_i & resp_v & (skid_full ? xfer : ~if_ready_i);
    if_pc_o    = if_valid_o ? ADDR_W'(head_word.pc) : '0;
    if_instr_o = if_valid_o ? DATA_W'(head_word.instr) : '0;
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .pop   (skid_pop),
    .clear (redirect_i),
    .din   (resp_word),
    .full  (skid_full),
    .dout  (skid_word)
  );

  // PC advance on issue, redirect retarget, and in-flight request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else begin
      req_q <= imem_req_o;
      if (redirect_i) begin
        pc_q <= {redirect_addr_i[ADDR_W-1:2], 2'b00};
      end else if (imem_req_o) begin
        pc_q     <= pc_q + ADDR_W'(PC_STEP);
        req_pc_q <= pc_q;
      end
    end
  end

  // Catch a response that lands while the skid entry is stalled in front of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_word_q <= '0;
    end else if (redirect_i) begin
      pend_q <= 1'b0;
    end else if (skid_full && xfer) begin
      pend_q <= 1'b0;
    end else if (skid_full && req_q) begin
      pend_q      <= 1'b1;
      pend_word_q <= live_word;
    end
  end

  // RUN/DRAIN/HALT sequencing; redirect always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      halted_o <= 1'b0;
    end else if (redirect_i) begin
      state_q  <= RUN;
      halted_o <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (halt_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!req_q && !skid_full && !pend_q) begin
            state_q  <= HALT;
            halted_o <= 1'b1;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q  <= RUN;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters of accepted transfers and decode stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (xfer && (perf_fetched_o != 32'hFFFF_FFFF))
        perf_fetched_o <= perf_fetched_o + 32'd1;
      if (if_valid_o && !if_ready_i && (perf_stall_o != 32'hFFFF_FFFF))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: vector table, directed halt/wrap/reset sequences,
// then randomized traffic against a program-order reference model.
module tb_pc_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] Addr_o;
  logic        imem_req_o;
  logic [31:0] instr_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        halt_i;
  logic        halted_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
`endif

  int checks;
  int errors;

  pc_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Addr_o          (Addr_o),
    .imem_req_o      (imem_req_o),
    .instr_i         (instr_i),
    .if_valid_o      (if_valid_o),
    .if_ready_i      (if_ready_i),
    .if_pc_o         (if_pc_o),
    .if_instr_o      (if_instr_o),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .halt_i          (halt_i),
    .halted_o        (halted_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o  (perf_fetched_o),
    .perf_stall_o    (perf_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data is a fixed function of the address.
  always @(posedge clk) begin
    instr_i <= imem_req_o ? (Addr_o ^ KEY) : 32'h0BAD_F00D;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic rd, input logic [31:0] ra, input logic hl);
    @(negedge clk);
    rst_n           = 1'b1;
    if_ready_i      = rdy;
    redirect_i      = rd;
    redirect_addr_i = ra;
    halt_i          = hl;
    #1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] raddr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [13];

  // Reference model state for the randomized phase.
  logic [31:0] m_iss, m_acc;
  int          m_out, m_cnt;
  logic        m_halt, m_valid;
  logic        rdy, rd, hl;
  logic [31:0] ra;
  int          nx;
`ifdef FETCH_PERF_EN
  int          m_fetch, m_stall;
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if_ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_addr_i = '0;
    halt_i = 1'b0;

    // ready, redirect, target, req, Addr_o, valid, if_pc_o
    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'hC};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h14,  1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr",   Addr_o, 32'h0);
    chk("rst_req",    32'(imem_req_o), 32'd0);
    chk("rst_valid",  32'(if_valid_o), 32'd0);
    chk("rst_pc",     if_pc_o, 32'h0);
    chk("rst_instr",  if_instr_o, 32'h0);
    chk("rst_halted", 32'(halted_o), 32'd0);

    // Streaming, backpressure, redirect vectors (row 0 releases reset)
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ready, tbl[i].redir, tbl[i].raddr, 1'b0);
      chk($sformatf("tbl%0d_req", i),   32'(imem_req_o), 32'(tbl[i].exp_req));
      chk($sformatf("tbl%0d_addr", i),  Addr_o, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(if_valid_o), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i),    if_pc_o, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_instr", i), if_instr_o, tbl[i].exp_pc ^ KEY);
      end
    end

    // Halt with one request in flight and the skid full
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("h0_req", 32'(imem_req_o), 32'd1);
    chk("h0_addr", Addr_o, 32'h10C);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("h1_req", 32'(imem_req_o), 32'd0);
    chk("h1_pc", if_pc_o, 32'h108);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("h2_pc", if_pc_o, 32'h108);
    chk("h2_req", 32'(imem_req_o), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("h3_valid", 32'(if_valid_o), 32'd1);
    chk("h3_pc", if_pc_o, 32'h10C);
    chk("h3_instr", if_instr_o, 32'h10C ^ KEY);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("h4_valid", 32'(if_valid_o), 32'd0);
    chk("h4_halted", 32'(halted_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("halted", 32'(halted_o), 32'd1);
      chk("halted_req", 32'(imem_req_o), 32'd0);
    end
    step(1'b1, 1'b1, 32'h40, 1'b0);
    chk("resume_halted", 32'(halted_o), 32'd1);
    chk("resume_req0", 32'(imem_req_o), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("resume_halted_clr", 32'(halted_o), 32'd0);
    chk("resume_addr", Addr_o, 32'h40);
    chk("resume_req1", 32'(imem_req_o), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("resume_pc", if_pc_o, 32'h40);

    // PC wraps modulo 2^32 after a misaligned redirect near the top
    step(1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0);
    chk("wrap_valid0", 32'(if_valid_o), 32'd0);
    begin
      logic [31:0] wa [4];
      wa[0] = 32'hFFFF_FFF8; wa[1] = 32'hFFFF_FFFC; wa[2] = 32'h0; wa[3] = 32'h4;
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk($sformatf("wrap%0d_addr", i), Addr_o, wa[i]);
        if (i > 0) chk($sformatf("wrap%0d_pc", i), if_pc_o, wa[i-1]);
      end
    end

    // Fresh reset; 3 stall cycles, then run to 10 transfers; reset mid-stream
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("stall_valid", 32'(if_valid_o), 32'd1);
      chk("stall_pc", if_pc_o, 32'h0);
    end
    nx = 0;
    for (int c = 0; c < 60 && nx < 10; c++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (if_valid_o) begin
        chk("perf_seq_pc", if_pc_o, 32'(nx * 4));
        nx++;
      end
    end
    chk("xfer_budget", 32'(nx), 32'd10);
    @(posedge clk);
    #1;
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched_o, 32'd10);
    chk("perf_stall", perf_stall_o, 32'd3);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if_valid_o), 32'd0);
    chk("mid_rst_req", 32'(imem_req_o), 32'd0);
    chk("mid_rst_addr", Addr_o, 32'h0);
    chk("mid_rst_pc", if_pc_o, 32'h0);
`ifdef FETCH_PERF_EN
    chk("mid_rst_perf_f", perf_fetched_o, 32'd0);
    chk("mid_rst_perf_s", perf_stall_o, 32'd0);
`endif

    // Randomized traffic against the program-order model
    m_iss = 32'h0; m_acc = 32'h0; m_out = 0; m_cnt = 0; m_halt = 1'b0;
`ifdef FETCH_PERF_EN
    m_fetch = 0; m_stall = 0;
`endif
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 39) == 0);
      hl  = ($urandom_range(0, 59) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      step(rdy, rd, ra, hl);
      if (m_halt && m_out == 0) m_cnt++;
      else m_cnt = 0;
      m_valid = !rd && (m_out > 0);
      chk("rnd_halted", 32'(halted_o), 32'(m_cnt >= 2));
      chk("rnd_valid", 32'(if_valid_o), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_pc", if_pc_o, m_acc);
        chk("rnd_instr", if_instr_o, m_acc ^ KEY);
      end
      if (rd || m_halt) chk("rnd_req_idle", 32'(imem_req_o), 32'd0);
      else if (m_out == 0) chk("rnd_req_live", 32'(imem_req_o), 32'd1);
      if (imem_req_o) chk("rnd_addr", Addr_o, m_iss);
      chk("rnd_outstanding_le2", 32'(m_out > 2), 32'd0);
`ifdef FETCH_PERF_EN
      if (m_valid && rdy)  m_fetch++;
      if (m_valid && !rdy) m_stall++;
`endif
      if (rd) begin
        m_iss  = {ra[31:2], 2'b00};
        m_acc  = {ra[31:2], 2'b00};
        m_out  = 0;
        m_halt = 1'b0;
      end else begin
        if (imem_req_o) begin
          m_out++;
          m_iss = m_iss + 32'd4;
        end
        if (m_valid && rdy) begin
          m_out--;
          m_acc = m_acc + 32'd4;
        end
        if (hl) m_halt = 1'b1;
      end
    end
    @(posedge clk);
    #1;
`ifdef FETCH_PERF_EN
    chk("rnd_perf_fetched", perf_fetched_o, 32'(m_fetch));
    chk("rnd_perf_stall", perf_stall_o, 32'(m_stall));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end for the pipelined processor: owns the program counter and issues sequential word addresses (+4 per fetch) to the synchronous instruction memory. It captures the returned instruction words and hands them to the IF/ID stage through a valid/ready handshake. It also absorbs decode backpressure in a one-entry skid buffer and services branch redirects and halt. This is the hardware producer of the fetch-address stream the CPU consumes on `Addr_in`.

## Interface
- `RESET_PC`, 32'd0, first fetch address after reset
- `ADDR_W`, 32, address/PC width
- `DATA_W`, 32, instruction width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `Addr_o` out ADDR_W: fetch address to instruction memory
- `imem_req_o` out 1: fetch issued this cycle
- `instr_i` in DATA_W: imem read data, valid the cycle after the request
- `if_valid_o` out 1: instruction offered to decode
- `if_ready_i` in 1: decode accepts
- `if_pc_o` out ADDR_W: PC of the offered instruction
- `if_instr_o` out DATA_W: offered instruction
- `redirect_i` in 1: branch/jump taken, one-cycle pulse
- `redirect_addr_i` in ADDR_W: redirect target
- `halt_i` in 1: stop fetching
- `halted_o` out 1: fetch idle, nothing outstanding

## Operation
- States: RUN, DRAIN, HALT.
  - RUN -> DRAIN on `halt_i`.
  - DRAIN -> HALT when no request is in flight and the skid buffer is empty.
  - Any state -> RUN on `redirect_i`.
- Issue rule: `imem_req_o` = (state==RUN) & skid empty & !`redirect_i`. On issue, `Addr_o`=pc, pc<=pc+4, req_q<=1, req_pc_q<=pc.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC+4 = 0. Redirect target bits [1:0] are forced to 0.
- Response: when req_q=1, `instr_i` with req_pc_q forms the response word.
  - Skid empty: the response passes straight through to `if_*`.
  - `if_ready_i`=0: the response is written into the skid buffer.
  - Skid occupied: the skid entry is offered first. No new requests are issued until it drains.
- Handshake: transfer occurs when `if_valid_o`&`if_ready_i`. `if_pc_o`/`if_instr_o` are held stable while valid and not ready.
- Redirect (highest priority, above halt and backpressure), in the redirect cycle:
  - the in-flight response is killed (`if_valid_o`=0);
  - the skid buffer is cleared;
  - no request is issued;
  - pc<=redirect target.
- Halt: outstanding response and skid entry are still delivered. `halted_o`=1 only in HALT.
- `redirect_i` together with `halt_i`: redirect wins. Halt is re-evaluated the next cycle.

## Timing
- Reset values:
  - pc=RESET_PC, `Addr_o`=RESET_PC
  - `imem_req_o`=0, `if_valid_o`=0
  - `if_pc_o`=0, `if_instr_o`=0
  - `halted_o`=0
  - state=RUN, skid empty, req_q=0
- First request: the first rising edge after `rst_n` deasserts.
- Fetch-to-offer latency: 1 cycle. Steady throughput is 1 instruction/cycle with `if_ready_i`=1.
- Redirect penalty: target issued 1 cycle after the redirect pulse; first valid target instruction 2 cycles after the pulse.
- Backpressure: at most one request outstanding beyond a full skid buffer. No instruction is ever dropped or duplicated.
- `rst_n` asserted mid-operation: all state clears immediately; any in-flight response is discarded.
- `Addr_o` is combinational from pc, so it is valid in the issue cycle.

## Configuration
- `FETCH_PERF_EN` defined: adds 32-bit outputs `perf_fetched_o` and `perf_stall_o`.
  - `perf_fetched_o`: accepted transfers.
  - `perf_stall_o`: cycles with `if_valid_o`&!`if_ready_i`.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- `FETCH_PERF_EN` undefined: neither port nor counter logic exists.

## Structure
- `fetch_pkg` holds:
  - the state enum {RUN, DRAIN, HALT};
  - `PC_STEP`=4;
  - a `fetch_word_t` struct {pc, instr}.
- One sub-module, `fetch_skid_buf`: one-entry buffer with load/clear/pop, full flag and `fetch_word_t` data.

## Test plan
- Reset release, `if_ready_i`=1, imem returns instr=addr^32'hA5A5_0000 -> `Addr_o` is 0,4,8,… each cycle; each `if_pc_o` is offered one cycle after its issue with the matching instr.
- `if_ready_i` low for 3 cycles during streaming -> skid fills, `imem_req_o`=0 while full. On release, PCs continue in order with no gap and no duplicate.
- `redirect_i` with target 32'h0000_0103 while PC 0x10 is in flight -> 0x10 is never offered. `Addr_o`=0x100 on the next cycle; first valid `if_pc_o`=0x100 two cycles after the pulse.
- `halt_i` with one request in flight and the skid full -> both words delivered, then `halted_o`=1 and no requests. A later redirect to 0x40 resumes fetching at 0x40.
- Redirect to 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0, 4.
- `FETCH_PERF_EN`: 10 transfers plus 3 stall cycles -> `perf_fetched_o`=10, `perf_stall_o`=3. Asserting `rst_n` low mid-stream clears both counters and `if_valid_o` at once.
